// File: rtl/cache_l1_msi_pkg.sv
// ---------------------------------------------------------------------------
// cache_l1_msi_pkg
// Shared encodings for the MSI L1 cache: line coherence states, directory
// request opcodes, snoop opcodes and the controller FSM states.
// Also holds the snoop state-transition helper used by the controller.
// ---------------------------------------------------------------------------
package cache_l1_msi_pkg;

   typedef enum logic [1:0] {
      MSI_I = 2'd0,
      MSI_S = 2'd1,
      MSI_M = 2'd2
   } msiState_t;

   typedef enum logic [1:0] {
      DIR_READ_MISS  = 2'd0,
      DIR_WRITE_MISS = 2'd1,
      DIR_WRITEBACK  = 2'd2
   } dirOp_t;

   typedef enum logic [1:0] {
      SNP_INVALIDATE = 2'd0,
      SNP_FETCH      = 2'd1,
      SNP_FETCH_INV  = 2'd2
   } snpOp_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WB        = 3'd1,
      ST_MISS_REQ  = 3'd2,
      ST_WAIT_FILL = 3'd3,
      ST_RESP      = 3'd4
   } fsmState_t;

   // State a present line moves to when a snoop of the given kind hits it.
   // FETCH only downgrades a modified line; a shared line stays shared.
   function automatic msiState_t snoopNextState(input snpOp_t op, input msiState_t cur);
      msiState_t nxt;
      nxt = cur;
      case (op)
         SNP_INVALIDATE: nxt = MSI_I;
         SNP_FETCH_INV:  nxt = MSI_I;
         SNP_FETCH:      nxt = (cur == MSI_M) ? MSI_S : cur;
         default:        nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/cache_l1_array.sv
// ---------------------------------------------------------------------------
// cache_l1_array
// Direct-mapped tag/state/data storage for the L1 cache.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cpuIdx -> cpuTag/State/Data   combinational lookup for the CPU side
//   wrEn/wrIdx/wrTag/wrState/wrData  full-line write port
//   snpIdx -> snpTag/State/Data   combinational lookup for the snoop side
//   snpStEn/snpStNext             snoop-driven state-only update
// Only the coherence state is reset; tag and data contents are don't-care
// while a line is invalid.
// ---------------------------------------------------------------------------
module cache_l1_array
   import cache_l1_msi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int SETS   = 2,
   parameter int IDX_W  = 1,
   parameter int TAG_W  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  cpuIdx,
   output logic [TAG_W-1:0]  cpuTag,
   output msiState_t         cpuState,
   output logic [DATA_W-1:0] cpuData,
   input  logic              wrEn,
   input  logic [IDX_W-1:0]  wrIdx,
   input  logic [TAG_W-1:0]  wrTag,
   input  msiState_t         wrState,
   input  logic [DATA_W-1:0] wrData,
   input  logic [IDX_W-1:0]  snpIdx,
   output logic [TAG_W-1:0]  snpTag,
   output msiState_t         snpState,
   output logic [DATA_W-1:0] snpData,
   input  logic              snpStEn,
   input  msiState_t         snpStNext
);

   logic [TAG_W-1:0]  tagMem  [SETS];
   logic [DATA_W-1:0] dataMem [SETS];
   msiState_t         lineState [SETS];

   always_ff @(posedge clk) begin
      if (wrEn) begin
         tagMem[wrIdx]  <= wrTag;
         dataMem[wrIdx] <= wrData;
      end
   end

   // When a snoop and a full-line write land on the same line in one cycle,
   // the full-line write wins: the snoop has already been answered from the
   // old contents, and the fill must take effect afterwards.
   generate
      for (genvar gi = 0; gi < SETS; gi++) begin : gLine
         msiState_t stateReg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stateReg <= MSI_I;
            end else if (wrEn && (wrIdx == IDX_W'(gi))) begin
               stateReg <= wrState;
            end else if (snpStEn && (snpIdx == IDX_W'(gi))) begin
               stateReg <= snpStNext;
            end
         end
         assign lineState[gi] = stateReg;
      end
   endgenerate

   assign cpuTag   = tagMem[cpuIdx];
   assign cpuState = lineState[cpuIdx];
   assign cpuData  = dataMem[cpuIdx];
   assign snpTag   = tagMem[snpIdx];
   assign snpState = lineState[snpIdx];
   assign snpData  = dataMem[snpIdx];

endmodule

// File: rtl/cache_l1_msi.sv
// ---------------------------------------------------------------------------
// cache_l1_msi
// Direct-mapped, one-word-per-line L1 cache with MSI coherence.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cpu_req_*         processor request (valid/ready, write, addr, wdata)
//   cpu_rsp_*         one-cycle completion pulse with read/written data
//   dir_req_*         request to directory (READ_MISS/WRITE_MISS/WRITEBACK)
//   dir_fill_*        fill pulse from directory
//   snp_*             snoop request in, ack/hit/data out
// ---------------------------------------------------------------------------
module cache_l1_msi
   import cache_l1_msi_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int SETS   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_valid,
   output logic              cpu_req_ready,
   input  logic              cpu_req_write,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   input  logic [DATA_W-1:0] cpu_req_wdata,
   output logic              cpu_rsp_valid,
   output logic [DATA_W-1:0] cpu_rsp_data,
   output logic              dir_req_valid,
   input  logic              dir_req_ready,
   output logic [1:0]        dir_req_op,
   output logic [ADDR_W-1:0] dir_req_addr,
   output logic [DATA_W-1:0] dir_req_data,
   input  logic              dir_fill_valid,
   input  logic [DATA_W-1:0] dir_fill_data,
   input  logic              snp_valid,
   input  logic [1:0]        snp_op,
   input  logic [ADDR_W-1:0] snp_addr,
   output logic              snp_ack,
   output logic              snp_hit,
   output logic [DATA_W-1:0] snp_data
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W;

   fsmState_t         state;
   logic              reqWrite;
   logic [ADDR_W-1:0] reqAddr;
   logic [DATA_W-1:0] reqWdata;
   logic              rspValid;
   logic [DATA_W-1:0] rspData;
   logic              dirValid;
   dirOp_t            dirOp;
   logic [ADDR_W-1:0] dirAddr;
   logic [DATA_W-1:0] dirData;
   logic              snpAckR;
   logic              snpHitR;
   logic [DATA_W-1:0] snpDataR;

   // CPU-side lookup follows the live request in IDLE and the latched
   // request everywhere else.
   logic [ADDR_W-1:0] lookAddr;
   logic [IDX_W-1:0]  lookIdx;
   logic [TAG_W-1:0]  lookTag;
   logic [TAG_W-1:0]  arrCpuTag;
   msiState_t         arrCpuState;
   logic [DATA_W-1:0] arrCpuData;

   logic [IDX_W-1:0]  snpIdx;
   logic [TAG_W-1:0]  arrSnpTag;
   msiState_t         arrSnpState;
   logic [DATA_W-1:0] arrSnpData;
   msiState_t         snpNext;
   logic              snpService;
   logic              snpLineHit;
   logic              snpLineDirty;
   logic              snpStEn;

   logic              wrEn;
   logic [TAG_W-1:0]  wrTag;
   msiState_t         wrState;
   logic [DATA_W-1:0] wrData;

   logic              accept;
   logic              tagMatch;
   logic              readHit;
   logic              writeHit;
   logic              victimDirty;

   assign lookAddr = (state == ST_IDLE) ? cpu_req_addr : reqAddr;
   assign lookIdx  = lookAddr[IDX_W-1:0];
   assign lookTag  = lookAddr[ADDR_W-1:IDX_W];

   assign cpu_req_ready = (state == ST_IDLE) && !snp_valid && !rst;
   assign accept        = cpu_req_valid && cpu_req_ready;

   assign tagMatch    = (arrCpuTag == lookTag);
   assign readHit     = !cpu_req_write && tagMatch && (arrCpuState != MSI_I);
   assign writeHit    = cpu_req_write && tagMatch && (arrCpuState == MSI_M);
   // A miss only needs a writeback when a modified line of another tag
   // occupies the set; a modified line of the same tag is always a hit.
   assign victimDirty = (arrCpuState == MSI_M) && !tagMatch;

   // Snoops are taken once per snp_valid assertion: the ack cycle itself
   // still sees snp_valid high and must not be serviced again.
   assign snpIdx       = snp_addr[IDX_W-1:0];
   assign snpService   = snp_valid && !snpAckR &&
                         ((state == ST_IDLE) || (state == ST_WAIT_FILL));
   assign snpLineHit   = (arrSnpTag == snp_addr[ADDR_W-1:IDX_W]) && (arrSnpState != MSI_I);
   assign snpLineDirty = snpLineHit && (arrSnpState == MSI_M);
   assign snpNext      = snoopNextState(snpOp_t'(snp_op), arrSnpState);
   assign snpStEn      = snpService && snpLineHit;

   always_comb begin
      wrEn    = 1'b0;
      wrTag   = lookTag;
      wrState = MSI_I;
      wrData  = reqWdata;
      case (state)
         ST_IDLE: begin
            if (accept && writeHit) begin
               wrEn    = 1'b1;
               wrState = MSI_M;
               wrData  = cpu_req_wdata;
            end
         end
         ST_WB: begin
            if (dir_req_ready) begin
               wrEn    = 1'b1;
               wrTag   = dirAddr[ADDR_W-1:IDX_W];
               wrState = MSI_I;
               wrData  = dirData;
            end
         end
         ST_WAIT_FILL: begin
            if (dir_fill_valid) begin
               wrEn    = 1'b1;
               wrState = reqWrite ? MSI_M : MSI_S;
               wrData  = reqWrite ? reqWdata : dir_fill_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         reqWrite <= 1'b0;
         reqAddr  <= '0;
         reqWdata <= '0;
         rspValid <= 1'b0;
         rspData  <= '0;
         dirValid <= 1'b0;
         dirOp    <= DIR_READ_MISS;
         dirAddr  <= '0;
         dirData  <= '0;
         snpAckR  <= 1'b0;
         snpHitR  <= 1'b0;
         snpDataR <= '0;
      end else begin
         rspValid <= 1'b0;
         snpAckR  <= snpService;
         snpHitR  <= snpService && snpLineDirty;
         snpDataR <= (snpService && snpLineDirty) ? arrSnpData : '0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  reqWrite <= cpu_req_write;
                  reqAddr  <= cpu_req_addr;
                  reqWdata <= cpu_req_wdata;
                  if (readHit || writeHit) begin
                     rspData  <= readHit ? arrCpuData : cpu_req_wdata;
                     rspValid <= 1'b1;
                     state    <= ST_RESP;
                  end else if (victimDirty) begin
                     dirValid <= 1'b1;
                     dirOp    <= DIR_WRITEBACK;
                     dirAddr  <= {arrCpuTag, lookIdx};
                     dirData  <= arrCpuData;
                     state    <= ST_WB;
                  end else begin
                     dirValid <= 1'b1;
                     dirOp    <= cpu_req_write ? DIR_WRITE_MISS : DIR_READ_MISS;
                     dirAddr  <= cpu_req_addr;
                     dirData  <= cpu_req_write ? cpu_req_wdata : '0;
                     state    <= ST_MISS_REQ;
                  end
               end
            end
            ST_WB: begin
               // Valid stays high: the miss request follows immediately.
               if (dir_req_ready) begin
                  dirOp   <= reqWrite ? DIR_WRITE_MISS : DIR_READ_MISS;
                  dirAddr <= reqAddr;
                  dirData <= reqWrite ? reqWdata : '0;
                  state   <= ST_MISS_REQ;
               end
            end
            ST_MISS_REQ: begin
               if (dir_req_ready) begin
                  dirValid <= 1'b0;
                  state    <= ST_WAIT_FILL;
               end
            end
            ST_WAIT_FILL: begin
               if (dir_fill_valid) begin
                  rspData  <= reqWrite ? reqWdata : dir_fill_data;
                  rspValid <= 1'b1;
                  state    <= ST_RESP;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign cpu_rsp_valid = rspValid;
   assign cpu_rsp_data  = rspData;
   assign dir_req_valid = dirValid;
   assign dir_req_op    = dirOp;
   assign dir_req_addr  = dirAddr;
   assign dir_req_data  = dirData;
   assign snp_ack       = snpAckR;
   assign snp_hit       = snpHitR;
   assign snp_data      = snpDataR;

   cache_l1_array #(
      .DATA_W (DATA_W),
      .SETS   (SETS),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W)
   ) uArray (
      .clk       (clk),
      .rst       (rst),
      .cpuIdx    (lookIdx),
      .cpuTag    (arrCpuTag),
      .cpuState  (arrCpuState),
      .cpuData   (arrCpuData),
      .wrEn      (wrEn),
      .wrIdx     (lookIdx),
      .wrTag     (wrTag),
      .wrState   (wrState),
      .wrData    (wrData),
      .snpIdx    (snpIdx),
      .snpTag    (arrSnpTag),
      .snpState  (arrSnpState),
      .snpData   (arrSnpData),
      .snpStEn   (snpStEn),
      .snpStNext (snpNext)
   );

endmodule

// File: tb/tb_cache_l1_msi.sv
// ---------------------------------------------------------------------------
// tb_cache_l1_msi
// Directed self-checking bench for cache_l1_msi (ADDR_W=8, DATA_W=8,
// SETS=2: index = addr[0], so 0x12/0x14/0x16 share set 0, 0x13/0x15 set 1).
// ---------------------------------------------------------------------------
module tb_cache_l1_msi;

   localparam logic [1:0] OP_RM  = 2'd0;
   localparam logic [1:0] OP_WM  = 2'd1;
   localparam logic [1:0] OP_WB  = 2'd2;
   localparam logic [1:0] SN_INV = 2'd0;
   localparam logic [1:0] SN_F   = 2'd1;
   localparam logic [1:0] SN_FI  = 2'd2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cpu_req_valid = 1'b0;
   logic       cpu_req_ready;
   logic       cpu_req_write = 1'b0;
   logic [7:0] cpu_req_addr = 8'h00;
   logic [7:0] cpu_req_wdata = 8'h00;
   logic       cpu_rsp_valid;
   logic [7:0] cpu_rsp_data;
   logic       dir_req_valid;
   logic       dir_req_ready = 1'b0;
   logic [1:0] dir_req_op;
   logic [7:0] dir_req_addr;
   logic [7:0] dir_req_data;
   logic       dir_fill_valid = 1'b0;
   logic [7:0] dir_fill_data = 8'h00;
   logic       snp_valid = 1'b0;
   logic [1:0] snp_op = 2'd0;
   logic [7:0] snp_addr = 8'h00;
   logic       snp_ack;
   logic       snp_hit;
   logic [7:0] snp_data;

   int checks = 0;
   int failures = 0;
   int dirValidCycles = 0;
   int rspCycles = 0;

   cache_l1_msi #(.ADDR_W(8), .DATA_W(8), .SETS(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_req_valid  (cpu_req_valid),
      .cpu_req_ready  (cpu_req_ready),
      .cpu_req_write  (cpu_req_write),
      .cpu_req_addr   (cpu_req_addr),
      .cpu_req_wdata  (cpu_req_wdata),
      .cpu_rsp_valid  (cpu_rsp_valid),
      .cpu_rsp_data   (cpu_rsp_data),
      .dir_req_valid  (dir_req_valid),
      .dir_req_ready  (dir_req_ready),
      .dir_req_op     (dir_req_op),
      .dir_req_addr   (dir_req_addr),
      .dir_req_data   (dir_req_data),
      .dir_fill_valid (dir_fill_valid),
      .dir_fill_data  (dir_fill_data),
      .snp_valid      (snp_valid),
      .snp_op         (snp_op),
      .snp_addr       (snp_addr),
      .snp_ack        (snp_ack),
      .snp_hit        (snp_hit),
      .snp_data       (snp_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dir_req_valid) dirValidCycles <= dirValidCycles + 1;
      if (cpu_rsp_valid) rspCycles <= rspCycles + 1;
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Present a CPU request and hold it until accepted; returns just after
   // the accepting edge.
   task automatic cpuAccept(input logic w, input logic [7:0] a, input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk);
      cpu_req_valid = 1'b1;
      cpu_req_write = w;
      cpu_req_addr  = a;
      cpu_req_wdata = d;
      #1;
      while (!cpu_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cpu_accept_timeout", cpu_req_ready, 1);
      @(posedge clk);
      #1;
      cpu_req_valid = 1'b0;
      $display("cpu req write=%0d addr=%02h wdata=%02h accepted", w, a, d);
   endtask

   // Wait for a directory request, check it, optionally hold ready low for
   // holdCycles while checking stability, then complete the handshake.
   task automatic dirHandshake(input string name, input logic [1:0] op, input logic [7:0] a,
                               input logic chkData, input logic [7:0] d, input int holdCycles);
      int n;
      logic [1:0] op0;
      logic [7:0] a0;
      logic [7:0] d0;
      n = 0;
      @(negedge clk);
      while (!dir_req_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, dir_req_valid, 1);
      check({name, "_op"}, dir_req_op, op);
      check({name, "_addr"}, dir_req_addr, a);
      if (chkData) check({name, "_data"}, dir_req_data, d);
      op0 = dir_req_op;
      a0  = dir_req_addr;
      d0  = dir_req_data;
      for (int i = 0; i < holdCycles; i++) begin
         @(negedge clk);
         check({name, "_hold_valid"}, dir_req_valid, 1);
         check({name, "_hold_fields"}, {dir_req_op, dir_req_addr, dir_req_data}, {op0, a0, d0});
      end
      dir_req_ready = 1'b1;
      @(posedge clk);
      #1;
      dir_req_ready = 1'b0;
      $display("dir req op=%0d addr=%02h data=%02h taken", op0, a0, d0);
   endtask

   task automatic fillPulse(input logic [7:0] d);
      @(negedge clk);
      dir_fill_valid = 1'b1;
      dir_fill_data  = d;
      @(posedge clk);
      #1;
      dir_fill_valid = 1'b0;
      $display("dir fill data=%02h", d);
   endtask

   task automatic waitRsp(input string name, input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (!cpu_rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_rsp_valid"}, cpu_rsp_valid, 1);
      check({name, "_rsp_data"}, cpu_rsp_data, d);
      @(negedge clk);
      check({name, "_rsp_pulse"}, cpu_rsp_valid, 0);
      $display("cpu rsp data=%02h", cpu_rsp_data);
   endtask

   // Hit: response exactly one cycle after acceptance, no directory traffic.
   task automatic hitAccess(input string name, input logic w, input logic [7:0] a,
                            input logic [7:0] wd, input logic [7:0] expData);
      int dirBefore;
      cpuAccept(w, a, wd);
      dirBefore = dirValidCycles;
      @(negedge clk);
      check({name, "_rsp_valid"}, cpu_rsp_valid, 1);
      check({name, "_rsp_data"}, cpu_rsp_data, expData);
      @(negedge clk);
      check({name, "_rsp_pulse"}, cpu_rsp_valid, 0);
      check({name, "_no_dir"}, dirValidCycles, dirBefore);
      $display("cpu hit %s data=%02h", name, expData);
   endtask

   task automatic snoop(input string name, input logic [1:0] op, input logic [7:0] a,
                        input logic expHit, input logic [7:0] expData);
      @(negedge clk);
      snp_valid = 1'b1;
      snp_op    = op;
      snp_addr  = a;
      #1;
      check({name, "_blocks_cpu"}, cpu_req_ready, 0);
      @(negedge clk);
      check({name, "_ack"}, snp_ack, 1);
      check({name, "_hit"}, snp_hit, expHit);
      if (expHit) check({name, "_data"}, snp_data, expData);
      snp_valid = 1'b0;
      @(negedge clk);
      check({name, "_ack_pulse"}, snp_ack, 0);
      $display("snoop op=%0d addr=%02h hit=%0d data=%02h", op, a, expHit, expData);
   endtask

   initial begin
      int rspBefore;

      // Reset state
      @(negedge clk);
      check("rst_ready", cpu_req_ready, 0);
      check("rst_rsp_valid", cpu_rsp_valid, 0);
      check("rst_dir_valid", dir_req_valid, 0);
      check("rst_snp_ack", snp_ack, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", cpu_req_ready, 1);

      // Cold read miss, fill, then read hit
      cpuAccept(1'b0, 8'h12, 8'h00);
      dirHandshake("cold_rm", OP_RM, 8'h12, 1'b0, 8'h00, 0);
      fillPulse(8'hA5);
      waitRsp("cold_rd", 8'hA5);
      hitAccess("reread", 1'b0, 8'h12, 8'h00, 8'hA5);

      // Write to a shared line: upgrade miss, ready held low 5 cycles
      cpuAccept(1'b1, 8'h12, 8'h3C);
      dirHandshake("upg_wm", OP_WM, 8'h12, 1'b0, 8'h00, 5);
      fillPulse(8'h99);
      waitRsp("upg_wr", 8'h3C);
      hitAccess("wr_hit", 1'b1, 8'h12, 8'h44, 8'h44);
      hitAccess("rd_m", 1'b0, 8'h12, 8'h00, 8'h44);

      // Conflict miss on a modified line: writeback then read miss
      cpuAccept(1'b0, 8'h14, 8'h00);
      dirHandshake("evict_wb", OP_WB, 8'h12, 1'b1, 8'h44, 0);
      dirHandshake("evict_rm", OP_RM, 8'h14, 1'b0, 8'h00, 0);
      fillPulse(8'h5A);
      waitRsp("evict_rd", 8'h5A);

      // Clean victim needs no writeback; then FETCH_INV on the M line
      cpuAccept(1'b1, 8'h12, 8'h44);
      dirHandshake("clean_wm", OP_WM, 8'h12, 1'b0, 8'h00, 0);
      fillPulse(8'h00);
      waitRsp("clean_wr", 8'h44);
      snoop("snp_fi", SN_FI, 8'h12, 1'b1, 8'h44);
      snoop("snp_miss", SN_F, 8'h16, 1'b0, 8'h00);
      cpuAccept(1'b0, 8'h12, 8'h00);
      dirHandshake("after_fi_rm", OP_RM, 8'h12, 1'b0, 8'h00, 0);
      fillPulse(8'h77);
      waitRsp("after_fi_rd", 8'h77);

      // FETCH downgrades M to S: the next write must miss again
      cpuAccept(1'b1, 8'h12, 8'h21);
      dirHandshake("m_wm", OP_WM, 8'h12, 1'b0, 8'h00, 0);
      fillPulse(8'h00);
      waitRsp("m_wr", 8'h21);
      snoop("snp_fetch", SN_F, 8'h12, 1'b1, 8'h21);
      cpuAccept(1'b1, 8'h12, 8'h22);
      dirHandshake("down_wm", OP_WM, 8'h12, 1'b0, 8'h00, 0);
      fillPulse(8'h00);
      waitRsp("down_wr", 8'h22);

      // Snoop on another set coincident with a fill in WAIT_FILL
      cpuAccept(1'b1, 8'h13, 8'h31);
      dirHandshake("s1_wm", OP_WM, 8'h13, 1'b0, 8'h00, 0);
      fillPulse(8'h00);
      waitRsp("s1_wr", 8'h31);
      cpuAccept(1'b0, 8'h14, 8'h00);
      dirHandshake("co_wb", OP_WB, 8'h12, 1'b1, 8'h22, 0);
      dirHandshake("co_rm", OP_RM, 8'h14, 1'b0, 8'h00, 0);
      @(negedge clk);
      snp_valid = 1'b1; snp_op = SN_FI; snp_addr = 8'h13;
      dir_fill_valid = 1'b1; dir_fill_data = 8'hB7;
      @(posedge clk);
      #1;
      dir_fill_valid = 1'b0;
      @(negedge clk);
      check("co_snp_ack", snp_ack, 1);
      check("co_snp_hit", snp_hit, 1);
      check("co_snp_data", snp_data, 8'h31);
      check("co_rsp_valid", cpu_rsp_valid, 1);
      check("co_rsp_data", cpu_rsp_data, 8'hB7);
      snp_valid = 1'b0;
      $display("snoop+fill same cycle: snp addr=13 fill=B7");
      hitAccess("co_rd14", 1'b0, 8'h14, 8'h00, 8'hB7);
      cpuAccept(1'b0, 8'h13, 8'h00);
      dirHandshake("co_rm13", OP_RM, 8'h13, 1'b0, 8'h00, 0);
      fillPulse(8'h0D);
      waitRsp("co_rd13", 8'h0D);

      // Same-line INVALIDATE with fill: fill lands after, line ends M
      cpuAccept(1'b1, 8'h14, 8'h66);
      dirHandshake("sl_wm", OP_WM, 8'h14, 1'b0, 8'h00, 0);
      @(negedge clk);
      snp_valid = 1'b1; snp_op = SN_INV; snp_addr = 8'h14;
      dir_fill_valid = 1'b1; dir_fill_data = 8'hEE;
      @(posedge clk);
      #1;
      dir_fill_valid = 1'b0;
      @(negedge clk);
      check("sl_snp_ack", snp_ack, 1);
      check("sl_snp_hit", snp_hit, 0);
      check("sl_rsp_data", cpu_rsp_data, 8'h66);
      snp_valid = 1'b0;
      $display("snoop+fill same line: snp addr=14 inv, write data=66");
      hitAccess("sl_wr_hit", 1'b1, 8'h14, 8'h67, 8'h67);

      // Reset during WAIT_FILL
      cpuAccept(1'b0, 8'h15, 8'h00);
      dirHandshake("rw_rm", OP_RM, 8'h15, 1'b0, 8'h00, 0);
      rspBefore = rspCycles;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rw_ready", cpu_req_ready, 0);
      check("rw_dir_valid", dir_req_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      $display("reset pulse during WAIT_FILL");
      fillPulse(8'h88);
      @(negedge clk);
      @(negedge clk);
      check("rw_no_rsp", rspCycles, rspBefore);
      check("rw_ready_back", cpu_req_ready, 1);
      // Set 0 held 0x14 in M; after reset it must miss without writeback
      cpuAccept(1'b0, 8'h14, 8'h00);
      dirHandshake("rw_rm14", OP_RM, 8'h14, 1'b0, 8'h00, 0);
      fillPulse(8'h42);
      waitRsp("rw_rd14", 8'h42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cache_l1_msi.md
CACHE_L1_MSI -- requirements
Module: cache_l1_msi

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width.
REQ-002 Parameter DATA_W, default 8, line/word width (one word per line).
REQ-003 Parameter SETS, default 2, direct-mapped line count, power of two, >=2; IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cpu_req_valid  in  1  processor request present; cpu_req_ready  out  1  request accepted this cycle.
REQ-007 cpu_req_write  in  1  1=write, 0=read; cpu_req_addr  in  ADDR_W; cpu_req_wdata  in  DATA_W.
REQ-008 cpu_rsp_valid  out  1  one-cycle completion pulse; cpu_rsp_data  out  DATA_W  read data, or written data on writes.
REQ-009 dir_req_valid  out  1; dir_req_ready  in  1; dir_req_op  out  2  (READ_MISS=0, WRITE_MISS=1, WRITEBACK=2); dir_req_addr  out  ADDR_W; dir_req_data  out  DATA_W.
REQ-010 dir_fill_valid  in  1  fill pulse; dir_fill_data  in  DATA_W.
REQ-011 snp_valid  in  1  held until snp_ack; snp_op  in  2  (INVALIDATE=0, FETCH=1, FETCH_INV=2); snp_addr  in  ADDR_W.
REQ-012 snp_ack  out  1  one-cycle pulse; snp_hit  out  1  line present in M; snp_data  out  DATA_W  line data when snp_hit.

Function
REQ-013 Index = cpu_req_addr[IDX_W-1:0], tag = upper TAG_W bits; per line: tag, MSI state (I=0, S=1, M=2), data.
REQ-014 FSM states IDLE, WB, MISS_REQ, WAIT_FILL, RESP; cpu_req_ready=1 only in IDLE with no snp_valid.
REQ-015 IDLE hit: read hit (S or M) or write hit in M -> RESP next cycle, cpu_rsp_valid pulse one cycle after acceptance; write hit updates data.
REQ-016 IDLE miss (tag mismatch or I, or write to S): victim in M with different tag -> WB, else MISS_REQ; request fields latched at acceptance.
REQ-017 WB: dir_req_valid=1, op=WRITEBACK, victim address/data; on dir_req_ready victim -> I, go MISS_REQ.
REQ-018 MISS_REQ: dir_req_valid=1, op=READ_MISS or WRITE_MISS, latched address; on dir_req_ready -> WAIT_FILL.
REQ-019 dir_req_valid and payload SHALL stay stable until dir_req_ready sampled high.
REQ-020 WAIT_FILL on dir_fill_valid: read -> store fill data, state S, rsp_data=fill; write -> store cpu_req_wdata, state M; -> RESP.
REQ-021 RESP: cpu_rsp_valid=1 for exactly one cycle, -> IDLE.
REQ-022 Snoops serviced in IDLE and WAIT_FILL only; priority over same-cycle CPU request; snp_ack one cycle after snp_valid first sampled.
REQ-023 Snoop hit = tag match and state!=I; INVALIDATE -> I; FETCH: M -> S, snp_hit=1, data out; FETCH_INV: M -> I, snp_hit=1; S line -> I on FETCH_INV.
REQ-024 Snoop miss: snp_ack=1, snp_hit=0, no state change.
REQ-025 Snoop and fill in same WAIT_FILL cycle: snoop applied first to old contents, fill writes afterwards.
REQ-026 dir_fill_valid outside WAIT_FILL ignored.

Reset
REQ-027 rst asserted at any time: FSM -> IDLE, all line states I, all outputs 0 (cpu_req_ready returns 1 first cycle after release), pending request dropped.
REQ-028 Tag/data arrays need no reset.

Structure
REQ-029 Shared package holds MSI state encoding, dir_req_op and snp_op encodings, FSM state enum.
REQ-030 One sub-module cache_l1_array (tag/state/data storage, one CPU read port, one write port, one snoop lookup port).

Verification
REQ-031 Cold read 0x12, fill 0xA5 -> READ_MISS addr 0x12, cpu_rsp_data=0xA5, line S; reread -> rsp 1 cycle after accept, no dir_req.
REQ-032 Write 0x12=0x3C to S line -> WRITE_MISS, after fill line M data 0x3C; second write 0x12=0x44 hits, no dir_req.
REQ-033 Line M (0x12,0x44), read 0x14 (same set, SETS=2) -> WRITEBACK addr 0x12 data 0x44 then READ_MISS 0x14.
REQ-034 Line M 0x12, snoop FETCH_INV 0x12 -> snp_ack, snp_hit=1, snp_data=0x44, line I; snoop 0x16 -> snp_hit=0.
REQ-035 dir_req_ready held low 5 cycles -> dir_req fields stable; snoop during WAIT_FILL with simultaneous fill -> both complete per REQ-025.
REQ-036 rst pulse in WAIT_FILL -> no cpu_rsp_valid, all lines I, later fill ignored.
